kernel_mem_bridge: RTL and testbench
====================================

KERNEL_MEM_BRIDGE -- requirements
Module: kernel_mem_bridge

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, giving the number of accelerator scratchpad ports (1..4).
REQ-002 SHALL have parameter ADDR_WID, default 14, giving the accelerator word-address width.
REQ-003 SHALL have parameter DATA_WID, default 32, giving the data width.
REQ-004 SHALL have parameter BYTE_SHIFT, default 2, giving the word-to-byte address shift.
REQ-005 SHALL have parameter TIMEOUT, default 0, giving the maximum host wait in clk cycles (0 = disabled).
REQ-006 SHALL have ports: clk  in  1  system clock; reset  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high).
REQ-007 SHALL have ports: start  in  1  run request; read_base, write_base  in  64  byte bases; xfer_size  in  64  per-access size.
REQ-008 SHALL have ports: read_enable  out  1; read_addr  out  64; read_size_output  out  64; read_ready  in  1; read_data  in  DATA_WID.
REQ-009 SHALL have ports: write_enable  out  1; write_addr  out  64; write_size  out  64; write_data  out  DATA_WID; write_ready  in  1.
REQ-010 SHALL have ports: acc_clk  out  1  stepped accelerator clock; acc_start  out  1; acc_done  in  1.
REQ-011 SHALL have ports: acc_ce, acc_we  in  NUM_PORTS; acc_addr  in  NUM_PORTS*ADDR_WID; acc_d  in  NUM_PORTS*DATA_WID; acc_q  out  NUM_PORTS*DATA_WID (port p in slice p).
REQ-012 SHALL have ports: done, busy, error  out  1; num_steps  out  64; num_reads, num_writes  out  32.

Function
REQ-013 SHALL implement states IDLE, CLK_HIGH, CLK_LOW, SCAN, REQ, WAIT, FINISH.
REQ-014 IDLE: acc_clk=0, busy=0; start=1 -> clear counters and error, latch xfer_size into read_size_output/write_size, busy=1, acc_start=1, go CLK_HIGH.
REQ-015 CLK_HIGH lasts exactly one clk cycle with acc_clk=1; at its closing edge latch acc_ce into a pending mask (pending[p]=acc_ce[p]), plus acc_we, acc_addr, acc_d and acc_done.
REQ-016 CLK_LOW lasts exactly one clk cycle with acc_clk=0; num_steps increments by 1 (64-bit wrap).
REQ-017 SCAN: select lowest-index set pending bit p -> REQ; none pending and latched acc_done=1 -> FINISH; none pending and acc_done=0 -> CLK_HIGH.
REQ-018 REQ: lasts one cycle; read (we[p]=0) drives read_enable=1 and read_addr=read_base+(addr[p]<<BYTE_SHIFT); write drives write_enable=1, write_addr=write_base+(addr[p]<<BYTE_SHIFT), write_data=d[p]; then WAIT.
REQ-019 read_enable/write_enable SHALL be high only in REQ; addr/data outputs hold until the next REQ; ready is ignored in the REQ cycle.
REQ-020 WAIT: on the matching ready (read_ready for a read, write_ready for a write): a read loads acc_q slice p with read_data and increments num_reads; a write increments num_writes; clear pending[p], go SCAN.
REQ-021 Ports are serviced strictly in ascending index within a step; acc_clk SHALL stay low from CLK_LOW until every pending port is serviced.
REQ-022 acc_q slices SHALL change only in WAIT on read completion; unserviced slices hold their value across steps.
REQ-023 TIMEOUT>0: more than TIMEOUT consecutive WAIT cycles without ready -> error=1, go FINISH, pending discarded.
REQ-024 FINISH: done=1 for exactly one cycle, acc_start=0, busy=0, next state IDLE; error, counters and acc_q hold until the next accepted start.
REQ-025 start SHALL be ignored unless the state is IDLE; acc_done=1 with pending accesses SHALL finish only after all are serviced.
REQ-026 num_reads/num_writes SHALL wrap at 2^32.

Reset
REQ-027 reset=1 at any clk edge, including mid-WAIT, SHALL force IDLE, acc_clk=0, acc_start=0, all enables 0, done=busy=error=0, pending=0, acc_q=0, counters=0, all addr/size/data outputs 0, within that cycle.
REQ-028 An access in flight when reset is asserted SHALL be abandoned; a later ready SHALL have no effect.

Verification
REQ-029 NUM_PORTS=2, step 1 with ce=2'b11, we=2'b01, addr0=5, addr1=7, read_base=0x1000, write_base=0x2000 -> write_enable with write_addr 0x2014 first, then read_enable with read_addr 0x101C; acc_q[1]=read_data; num_reads=1, num_writes=1.
REQ-030 Step with ce=0, acc_done=0 -> acc_clk pattern 1,0 then 1 again after one SCAN cycle; num_steps increments by 1 per step; no enables asserted.
REQ-031 acc_done=1 on step 3 with ce=0 -> done pulses once, num_steps=3, busy falls, acc_start falls.
REQ-032 TIMEOUT=8, read ready withheld -> error=1 and done asserted on the 9th WAIT cycle; acc_q unchanged.
REQ-033 reset during WAIT, then ready pulse -> outputs all 0, state IDLE, no acc_q update; start afterwards runs normally.
REQ-034 start pulsed while busy -> ignored; counters not cleared.

Source files
------------

// File: rtl/kernel_mem_bridge_if.sv
// Host memory bus between the bridge (master) and the host memory system (slave).
interface kernel_mem_bridge_if #(
  parameter int DATA_WID = 32
);
  logic                read_enable;
  logic [63:0]         read_addr;
  logic [63:0]         read_size_output;
  logic                read_ready;
  logic [DATA_WID-1:0] read_data;
  logic                write_enable;
  logic [63:0]         write_addr;
  logic [63:0]         write_size;
  logic [DATA_WID-1:0] write_data;
  logic                write_ready;

  modport master (
    output read_enable, read_addr, read_size_output,
    input  read_ready, read_data,
    output write_enable, write_addr, write_size, write_data,
    input  write_ready
  );

  modport slave (
    input  read_enable, read_addr, read_size_output,
    output read_ready, read_data,
    input  write_enable, write_addr, write_size, write_data,
    output write_ready
  );
endinterface

// File: rtl/kernel_mem_bridge.sv
// Steps an accelerator clock one pulse at a time and serializes the scratchpad
// accesses of each step onto the host read/write bus, lowest port first.
module kernel_mem_bridge #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WID   = 14,
  parameter int DATA_WID   = 32,
  parameter int BYTE_SHIFT = 2,
  parameter int TIMEOUT    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [63:0]                   read_base,
  input  logic [63:0]                   write_base,
  input  logic [63:0]                   xfer_size,
  kernel_mem_bridge_if.master           mem,
  output logic                          acc_clk,
  output logic                          acc_start,
  input  logic                          acc_done,
  input  logic [NUM_PORTS-1:0]          acc_ce,
  input  logic [NUM_PORTS-1:0]          acc_we,
  input  logic [NUM_PORTS*ADDR_WID-1:0] acc_addr,
  input  logic [NUM_PORTS*DATA_WID-1:0] acc_d,
  output logic [NUM_PORTS*DATA_WID-1:0] acc_q,
  output logic                          done,
  output logic                          busy,
  output logic                          error,
  output logic [63:0]                   num_steps,
  output logic [31:0]                   num_reads,
  output logic [31:0]                   num_writes
);
  localparam int SW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {IDLE, CLK_HIGH, CLK_LOW, SCAN, REQ, WAIT, FINISH} state_t;

  state_t                             r_state, w_next;
  logic [NUM_PORTS-1:0]               r_pend, r_we;
  logic [NUM_PORTS-1:0][ADDR_WID-1:0] r_addr;
  logic [NUM_PORTS-1:0][DATA_WID-1:0] r_d, r_q;
  logic                               r_done_l;
  logic [SW-1:0]                      r_sel, w_sel;
  logic [31:0]                        r_wcnt;
  logic                               w_any, w_rdy, w_tmo;

  assign acc_q = r_q;

  // Lowest-index pending port wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (r_pend[p]) begin
        w_any = 1'b1;
        w_sel = SW'(p);
      end
    end
  end

  assign w_rdy = r_we[r_sel] ? mem.write_ready : mem.read_ready;
  // r_wcnt holds the number of already-expired WAIT cycles for this access.
  assign w_tmo = (TIMEOUT > 0) && (r_wcnt >= 32'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (start) w_next = CLK_HIGH;
      CLK_HIGH: w_next = CLK_LOW;
      CLK_LOW:  w_next = SCAN;
      SCAN: begin
        if (w_any)         w_next = REQ;
        else if (r_done_l) w_next = FINISH;
        else               w_next = CLK_HIGH;
      end
      REQ:      w_next = WAIT;
      WAIT: begin
        if (w_rdy)      w_next = SCAN;
        else if (w_tmo) w_next = FINISH;
      end
      FINISH:   w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    acc_clk          = (r_state == CLK_HIGH);
    busy             = (r_state != IDLE) && (r_state != FINISH);
    acc_start        = busy;
    done             = (r_state == FINISH);
    mem.read_enable  = (r_state == REQ) && !r_we[r_sel];
    mem.write_enable = (r_state == REQ) &&  r_we[r_sel];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend               <= '0;
      r_we                 <= '0;
      r_addr               <= '0;
      r_d                  <= '0;
      r_q                  <= '0;
      r_done_l             <= 1'b0;
      r_sel                <= '0;
      r_wcnt               <= '0;
      error                <= 1'b0;
      num_steps            <= '0;
      num_reads            <= '0;
      num_writes           <= '0;
      mem.read_addr        <= '0;
      mem.read_size_output <= '0;
      mem.write_addr       <= '0;
      mem.write_size       <= '0;
      mem.write_data       <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          num_steps            <= '0;
          num_reads            <= '0;
          num_writes           <= '0;
          error                <= 1'b0;
          mem.read_size_output <= xfer_size;
          mem.write_size       <= xfer_size;
        end
        CLK_HIGH: begin
          r_pend   <= acc_ce;
          r_we     <= acc_we;
          r_addr   <= acc_addr;
          r_d      <= acc_d;
          r_done_l <= acc_done;
        end
        CLK_LOW: num_steps <= num_steps + 64'd1;
        // Bus address/data are set up here so they are valid throughout REQ.
        SCAN: if (w_any) begin
          r_sel  <= w_sel;
          r_wcnt <= '0;
          if (r_we[w_sel]) begin
            mem.write_addr <= write_base + (64'(r_addr[w_sel]) << BYTE_SHIFT);
            mem.write_data <= r_d[w_sel];
          end else begin
            mem.read_addr  <= read_base + (64'(r_addr[w_sel]) << BYTE_SHIFT);
          end
        end
        WAIT: begin
          if (w_rdy) begin
            r_pend[r_sel] <= 1'b0;
            if (r_we[r_sel]) begin
              num_writes <= num_writes + 32'd1;
            end else begin
              r_q[r_sel] <= mem.read_data;
              num_reads  <= num_reads + 32'd1;
            end
          end else if (w_tmo) begin
            error  <= 1'b1;
            r_pend <= '0;
          end else begin
            r_wcnt <= r_wcnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_kernel_mem_bridge.sv
// Scoreboard bench for kernel_mem_bridge: stimulus pushes expected bus accesses,
// a negedge monitor/responder pops, checks and answers them.
module tb_kernel_mem_bridge;
  logic        clk, reset, start;
  logic [63:0] read_base, write_base, xfer_size;
  logic        acc_clk, acc_start, acc_done;
  logic [1:0]  acc_ce, acc_we;
  logic [27:0] acc_addr;
  logic [63:0] acc_d, acc_q;
  logic        done, busy, error;
  logic [63:0] num_steps;
  logic [31:0] num_reads, num_writes;

  kernel_mem_bridge_if #(.DATA_WID(32)) bus();

  kernel_mem_bridge #(
    .NUM_PORTS(2), .ADDR_WID(14), .DATA_WID(32), .BYTE_SHIFT(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .read_base(read_base), .write_base(write_base), .xfer_size(xfer_size),
    .mem(bus),
    .acc_clk(acc_clk), .acc_start(acc_start), .acc_done(acc_done),
    .acc_ce(acc_ce), .acc_we(acc_we), .acc_addr(acc_addr), .acc_d(acc_d), .acc_q(acc_q),
    .done(done), .busy(busy), .error(error),
    .num_steps(num_steps), .num_reads(num_reads), .num_writes(num_writes)
  );

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [31:0] data;
    int          port;
  } xact_t;

  xact_t       exp_q[$];
  logic [31:0] exp_accq[2];
  int          total, bad;
  bit          withhold;
  int          pulse_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor + memory responder.
  initial begin
    int cnt;
    int pulses_done;
    xact_t cur;
    logic [31:0] rd;
    cnt = 0; pulses_done = 0;
    exp_accq[0] = '0; exp_accq[1] = '0;
    bus.read_ready = 1'b0; bus.write_ready = 1'b0; bus.read_data = '0;
    forever begin
      @(negedge clk);
      bus.read_ready  = 1'b0;
      bus.write_ready = 1'b0;
      bus.read_data   = $urandom;
      if (reset) begin
        cnt = 0;
        exp_accq[0] = '0; exp_accq[1] = '0;
      end else if (pulse_cnt != pulses_done) begin
        pulses_done++;
        bus.read_ready  = 1'b1;
        bus.write_ready = 1'b1;
        bus.read_data   = 32'hDEAD_BEEF;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (cur.wr) bus.write_ready = 1'b1;
          else begin
            rd = $urandom;
            bus.read_data  = rd;
            bus.read_ready = 1'b1;
            exp_accq[cur.port] = rd;
          end
        end else if ($urandom_range(0, 1) == 1) begin
          // the non-matching ready must not complete the access
          if (cur.wr) bus.read_ready = 1'b1;
          else        bus.write_ready = 1'b1;
        end
      end
      if (bus.read_enable || bus.write_enable) begin
        chk("single enable", {63'd0, bus.read_enable & bus.write_enable}, 64'd0);
        chk("acc_clk low in req", {63'd0, acc_clk}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected req", {63'd0, bus.write_enable}, 64'd2);
        end else begin
          cur = exp_q.pop_front();
          chk("req kind", {63'd0, bus.write_enable}, {63'd0, cur.wr});
          if (cur.wr) begin
            chk("write addr", bus.write_addr, cur.addr);
            chk("write data", {32'd0, bus.write_data}, {32'd0, cur.data});
          end else begin
            chk("read addr", bus.read_addr, cur.addr);
          end
          if (!withhold) cnt = $urandom_range(1, 5);
        end
      end
    end
  end

  task automatic wait_hi(output int gap, output bit ok);
    ok = 1'b0; gap = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (acc_clk) begin gap = i; ok = 1'b1; return; end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ok = 1'b1;
    end
  endtask

  // mode 0: directed two-port step, 1: idle steps, 2: random accesses
  task automatic run(input int mode, input int nsteps, input bit busy_start);
    int gap; bit ok; int er, ew;
    logic [1:0] ce, we;
    logic [13:0] a[2];
    logic [31:0] d[2];
    er = 0; ew = 0;
    if (mode == 0) begin
      read_base = 64'h1000; write_base = 64'h2000;
    end else begin
      read_base = {$urandom, $urandom}; write_base = {$urandom, $urandom};
    end
    xfer_size = {$urandom, $urandom};
    @(negedge clk); start = 1'b1;
    for (int s = 1; s <= nsteps; s++) begin
      wait_hi(gap, ok);
      chk("acc_clk rise", {63'd0, ok}, 64'd1);
      if (!ok) return;
      if (mode == 1 && s > 1) chk("idle step period", gap, 3);
      if (busy_start && s == 2) start = 1'b1;
      d[0] = $urandom; d[1] = $urandom;
      a[0] = 14'($urandom); a[1] = 14'($urandom);
      ce = 2'($urandom); we = 2'($urandom);
      if (mode == 0) begin ce = 2'b11; we = 2'b01; a[0] = 14'd5; a[1] = 14'd7; end
      if (mode == 1) ce = 2'b00;
      acc_ce = ce; acc_we = we; acc_addr = {a[1], a[0]}; acc_d = {d[1], d[0]};
      acc_done = (s == nsteps);
      if (mode == 0) begin
        exp_q.push_back('{wr: 1'b1, addr: 64'h2014, data: d[0], port: 0});
        exp_q.push_back('{wr: 1'b0, addr: 64'h101C, data: 32'd0, port: 1});
        er = 1; ew = 1;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (ce[p]) begin
            exp_q.push_back('{wr: we[p],
                              addr: (we[p] ? write_base : read_base) + 64'(a[p]) * 64'd4,
                              data: d[p], port: p});
            if (we[p]) ew++; else er++;
          end
        end
      end
    end
    wait_done(ok);
    chk("done seen", {63'd0, ok}, 64'd1);
    if (!ok) return;
    chk("num_steps", num_steps, 64'(nsteps));
    chk("num_reads", {32'd0, num_reads}, 64'(er));
    chk("num_writes", {32'd0, num_writes}, 64'(ew));
    chk("error clear", {63'd0, error}, 64'd0);
    chk("busy at done", {63'd0, busy}, 64'd0);
    chk("acc_start at done", {63'd0, acc_start}, 64'd0);
    chk("read size", bus.read_size_output, xfer_size);
    chk("write size", bus.write_size, xfer_size);
    chk("queue drained", 64'(exp_q.size()), 64'd0);
    for (int p = 0; p < 2; p++) chk($sformatf("acc_q[%0d]", p), {32'd0, acc_q[p*32 +: 32]}, {32'd0, exp_accq[p]});
    @(negedge clk);
    chk("done one cycle", {63'd0, done}, 64'd0);
    acc_done = 1'b0; acc_ce = '0;
  endtask

  initial begin
    int gap, n; bit ok;
    logic [13:0] a;
    total = 0; bad = 0; withhold = 1'b0; pulse_cnt = 0;
    reset = 1'b1; start = 1'b0; acc_done = 1'b0; acc_ce = '0; acc_we = '0;
    acc_addr = '0; acc_d = '0; read_base = '0; write_base = '0; xfer_size = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst acc_clk", {63'd0, acc_clk}, 64'd0);
    chk("rst acc_start", {63'd0, acc_start}, 64'd0);
    chk("rst num_steps", num_steps, 64'd0);
    chk("rst acc_q", acc_q, 64'd0);
    chk("rst enables", {62'd0, bus.read_enable, bus.write_enable}, 64'd0);
    reset = 1'b0;

    run(0, 1, 1'b0);
    run(1, 3, 1'b1);
    for (int k = 0; k < 6; k++) run(2, $urandom_range(1, 6), 1'b0);

    // read ready withheld past the timeout
    withhold = 1'b1;
    read_base = {$urandom, $urandom};
    @(negedge clk); start = 1'b1;
    wait_hi(gap, ok);
    chk("tmo step", {63'd0, ok}, 64'd1);
    a = 14'($urandom);
    acc_ce = 2'b10; acc_we = 2'b00; acc_addr = {a, 14'd0}; acc_done = 1'b1;
    exp_q.push_back('{wr: 1'b0, addr: read_base + 64'(a) * 64'd4, data: 32'd0, port: 1});
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); if (bus.read_enable) ok = 1'b1; end
    chk("tmo req seen", {63'd0, ok}, 64'd1);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin @(negedge clk); n++; if (done) ok = 1'b1; end
    chk("tmo latency", 64'(n), 64'd10);
    chk("tmo error", {63'd0, error}, 64'd1);
    chk("tmo num_reads", {32'd0, num_reads}, 64'd0);
    chk("tmo acc_q", acc_q, {exp_accq[1], exp_accq[0]});
    @(negedge clk);
    chk("tmo error holds", {63'd0, error}, 64'd1);
    acc_done = 1'b0; acc_ce = '0;

    // reset in the middle of a WAIT
    @(negedge clk); start = 1'b1;
    wait_hi(gap, ok);
    a = 14'($urandom);
    acc_ce = 2'b01; acc_we = 2'b00; acc_addr = {14'd0, a}; acc_done = 1'b0;
    exp_q.push_back('{wr: 1'b0, addr: read_base + 64'(a) * 64'd4, data: 32'd0, port: 0});
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); if (bus.read_enable) ok = 1'b1; end
    chk("rw req seen", {63'd0, ok}, 64'd1);
    repeat (3) @(negedge clk);
    chk("busy in wait", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; acc_ce = '0;
    chk("rw busy", {63'd0, busy}, 64'd0);
    chk("rw error", {63'd0, error}, 64'd0);
    chk("rw acc_clk", {63'd0, acc_clk}, 64'd0);
    chk("rw counters", {num_steps[31:0], num_reads}, 64'd0);
    chk("rw read addr", bus.read_addr, 64'd0);
    chk("rw write addr", bus.write_addr, 64'd0);
    chk("rw sizes", bus.read_size_output | bus.write_size, 64'd0);
    chk("rw acc_q", acc_q, 64'd0);
    withhold = 1'b0;
    pulse_cnt++;
    repeat (3) @(negedge clk);
    chk("late ready acc_q", acc_q, 64'd0);
    chk("late ready reads", {32'd0, num_reads}, 64'd0);
    chk("late ready idle", {63'd0, busy}, 64'd0);
    run(2, 4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
